// File: rtl/ahb3_mtimer_pkg.sv
// Shared constants and helpers for the AHB3-Lite machine timer.
// Register offsets are word indices, as decoded from HADDR[7:2].
// Build option: AHB3_MTIMER_PRESCALER_EN adds the PRESCALE register and prescaler.
package ahb3_mtimer_pkg;

    // Register word indices (byte offset >> 2)
    localparam logic [5:0] OFS_CONTROL  = 6'h00;  // 0x00
    localparam logic [5:0] OFS_PRESCALE = 6'h01;  // 0x04
    localparam logic [5:0] OFS_IPENDING = 6'h02;  // 0x08
    localparam logic [5:0] OFS_IENABLE  = 6'h03;  // 0x0C
    localparam logic [5:0] OFS_TIME_LO  = 6'h04;  // 0x10
    localparam logic [5:0] OFS_TIME_HI  = 6'h05;  // 0x14
    localparam logic [5:0] OFS_TIMECMP  = 6'h06;  // 0x18, two words per channel

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HSIZE encodings
    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Byte lanes touched by a transfer; any size above word acts as a word.
    function automatic logic [3:0] byte_enable(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr;
            HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replace the enabled byte lanes of old_v with those of new_v.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_v & ~mask) | (new_v & mask);
    endfunction

endpackage

// File: rtl/ahb3_mtimer_ahb_if.sv
// AHB3-Lite slave front end: captures the address phase and presents the
// data-phase address, direction, byte enables and a valid flag.
// Handshake: an address phase is taken when i_hsel & i_hready & i_htrans[1];
// the following cycle is its data phase (o_dp_valid=1). This slave never
// stalls, so every accepted address phase completes in exactly one data cycle.
module ahb3_mtimer_ahb_if
    import ahb3_mtimer_pkg::*;
#(
    parameter int HADDR_SIZE = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_hsel,
    input  logic [HADDR_SIZE-1:0] i_haddr,
    input  logic                  i_hwrite,
    input  logic [2:0]            i_hsize,
    input  logic [1:0]            i_htrans,
    input  logic                  i_hready,
    output logic                  o_dp_valid,
    output logic                  o_dp_write,
    output logic [HADDR_SIZE-1:0] o_dp_addr,
    output logic [3:0]            o_dp_be
);

    logic                  r_valid;
    logic                  r_write;
    logic [HADDR_SIZE-1:0] r_addr;
    logic [2:0]            r_size;
    logic                  w_accept;
    logic                  w_unused;

    // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY never start a data phase.
    assign w_accept = i_hsel & i_hready & i_htrans[1];
    assign w_unused = i_htrans[0];

    // Latch address-phase controls; the valid flag lives for one data cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_size  <= HSIZE_BYTE;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_write <= i_hwrite;
            r_addr  <= i_haddr;
            r_size  <= i_hsize;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign o_dp_valid = r_valid;
    assign o_dp_write = r_write;
    assign o_dp_addr  = r_addr;
    assign o_dp_be    = byte_enable(r_size, r_addr[1:0]);

endmodule

// File: rtl/ahb3_mtimer.sv
// AHB3-Lite RISC-V style machine timer: 64-bit TIME counter, TIMERS 64-bit
// compare channels, registered pending bits and a level interrupt.
// Build option: AHB3_MTIMER_PRESCALER_EN adds PRESCALE/PCNT; without it TIME
// advances every cycle while enabled and offset 0x04 reads zero.
module ahb3_mtimer
    import ahb3_mtimer_pkg::*;
#(
    parameter int TIMERS     = 3,
    parameter int HADDR_SIZE = 16,
    parameter int HDATA_SIZE = 32
) (
    input  logic                  HRESETn,
    input  logic                  HCLK,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic                  tint
);

    logic                  w_dp_valid;
    logic                  w_dp_write;
    logic [HADDR_SIZE-1:0] w_dp_addr;
    logic [3:0]            w_dp_be;
    logic [5:0]            w_idx;
    logic                  w_wr;
    logic                  w_wr_ctrl;
    logic                  w_tick;
    logic [31:0]           w_ctrl_new;
    logic [31:0]           w_ien_new;
    logic [31:0]           w_rdata;
    logic [TIMERS-1:0]     w_ipend_next;
    logic                  w_unused;

    logic                  r_en;
    logic [TIMERS-1:0]     r_ienable;
    logic [TIMERS-1:0]     r_ipend;
    logic                  r_tint;
    logic [63:0]           r_time;
    logic [63:0]           r_timecmp [TIMERS];

    ahb3_mtimer_ahb_if #(
        .HADDR_SIZE (HADDR_SIZE)
    ) u_ahb_if (
        .i_clk      (HCLK),
        .i_rst_n    (HRESETn),
        .i_hsel     (HSEL),
        .i_haddr    (HADDR),
        .i_hwrite   (HWRITE),
        .i_hsize    (HSIZE),
        .i_htrans   (HTRANS),
        .i_hready   (HREADY),
        .o_dp_valid (w_dp_valid),
        .o_dp_write (w_dp_write),
        .o_dp_addr  (w_dp_addr),
        .o_dp_be    (w_dp_be)
    );

    assign w_idx      = w_dp_addr[7:2];
    assign w_wr       = w_dp_valid & w_dp_write;
    assign w_wr_ctrl  = w_wr && (w_idx == OFS_CONTROL);
    assign w_ctrl_new = merge_bytes({31'b0, r_en}, HWDATA, w_dp_be);
    assign w_ien_new  = merge_bytes({{(32-TIMERS){1'b0}}, r_ienable}, HWDATA, w_dp_be);
    assign w_unused   = ^{HBURST, HPROT, HMASTLOCK, w_dp_addr, w_ctrl_new[31:1], w_ien_new};

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign HRDATA    = w_rdata;
    assign tint      = r_tint;

`ifdef AHB3_MTIMER_PRESCALER_EN
    logic        w_wr_presc;
    logic [31:0] r_prescale;
    logic [31:0] r_pcnt;

    assign w_wr_presc = w_wr && (w_idx == OFS_PRESCALE);
    assign w_tick     = r_en && (r_pcnt == r_prescale);

    // PRESCALE register and the prescaler count; any control or prescale write restarts the count.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_prescale <= '0;
            r_pcnt     <= '0;
        end else begin
            if (w_wr_presc)
                r_prescale <= merge_bytes(r_prescale, HWDATA, w_dp_be);
            if (!r_en || w_wr_ctrl || w_wr_presc || w_tick)
                r_pcnt <= '0;
            else
                r_pcnt <= r_pcnt + 32'd1;
        end
    end
`else
    assign w_tick = r_en;
`endif

    // CONTROL and IENABLE registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_en      <= 1'b0;
            r_ienable <= '0;
        end else begin
            if (w_wr_ctrl)
                r_en <= w_ctrl_new[0];
            if (w_wr && (w_idx == OFS_IENABLE))
                r_ienable <= w_ien_new[TIMERS-1:0];
        end
    end

    // TIME counter; a bus write to either half replaces the tick for that cycle, no carry.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_time <= '0;
        end else if (w_wr && (w_idx == OFS_TIME_LO)) begin
            r_time[31:0] <= merge_bytes(r_time[31:0], HWDATA, w_dp_be);
        end else if (w_wr && (w_idx == OFS_TIME_HI)) begin
            r_time[63:32] <= merge_bytes(r_time[63:32], HWDATA, w_dp_be);
        end else if (w_tick) begin
            r_time <= r_time + 64'd1;
        end
    end

    // TIMECMP registers, reset to all ones so nothing fires out of reset.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int n = 0; n < TIMERS; n++)
                r_timecmp[n] <= '1;
        end else begin
            for (int n = 0; n < TIMERS; n++) begin
                if (w_wr && (w_idx == 6'(OFS_TIMECMP + 6'(2 * n))))
                    r_timecmp[n][31:0] <= merge_bytes(r_timecmp[n][31:0], HWDATA, w_dp_be);
                if (w_wr && (w_idx == 6'(OFS_TIMECMP + 6'(2 * n + 1))))
                    r_timecmp[n][63:32] <= merge_bytes(r_timecmp[n][63:32], HWDATA, w_dp_be);
            end
        end
    end

    // Unsigned 64-bit comparison per channel.
    always_comb begin
        w_ipend_next = '0;
        for (int n = 0; n < TIMERS; n++)
            w_ipend_next[n] = (r_time >= r_timecmp[n]);
    end

    // Pending bits and interrupt are registered together.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_ipend <= '0;
            r_tint  <= 1'b0;
        end else begin
            r_ipend <= w_ipend_next;
            r_tint  <= |(w_ipend_next & r_ienable);
        end
    end

    // Read mux from the latched data-phase address; unmapped or idle reads zero.
    always_comb begin
        w_rdata = '0;
        if (w_dp_valid) begin
            case (w_idx)
                OFS_CONTROL:  w_rdata[0] = r_en;
`ifdef AHB3_MTIMER_PRESCALER_EN
                OFS_PRESCALE: w_rdata = r_prescale;
`else
                OFS_PRESCALE: w_rdata = '0;
`endif
                OFS_IPENDING: w_rdata[TIMERS-1:0] = r_ipend;
                OFS_IENABLE:  w_rdata[TIMERS-1:0] = r_ienable;
                OFS_TIME_LO:  w_rdata = r_time[31:0];
                OFS_TIME_HI:  w_rdata = r_time[63:32];
                default: begin
                    for (int n = 0; n < TIMERS; n++) begin
                        if (w_idx == 6'(OFS_TIMECMP + 6'(2 * n)))
                            w_rdata = r_timecmp[n][31:0];
                        if (w_idx == 6'(OFS_TIMECMP + 6'(2 * n + 1)))
                            w_rdata = r_timecmp[n][63:32];
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb3_mtimer.sv
// Directed and randomized bench for ahb3_mtimer with a register-level reference model.
`timescale 1ns/1ps
module tb_ahb3_mtimer;

  localparam int TIMERS = 3;
  localparam logic [31:0] IEN_MASK = 32'((1 << TIMERS) - 1);

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [15:0] HADDR = '0;
  logic [31:0] HWDATA = '0;
  logic [31:0] HRDATA;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'd2;
  logic [2:0]  HBURST = '0;
  logic [3:0]  HPROT = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HMASTLOCK = 1'b0;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic        tint;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  logic        m_en;
  logic [31:0] m_presc;
  logic [31:0] m_ien;
  logic [63:0] m_time;
  logic [63:0] m_cmp [TIMERS];

  assign HREADY = HREADYOUT;

  ahb3_mtimer #(.TIMERS(TIMERS), .HADDR_SIZE(16), .HDATA_SIZE(32)) dut (
    .HRESETn(HRESETn), .HCLK(HCLK), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .tint(tint)
  );

  // clock
  always #5 HCLK = ~HCLK;

  // ---------------- checks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input logic [31:0] obs, input logic [31:0] lo, input logic [31:0] hi);
    n_checks++;
    assert ((obs >= lo) && (obs <= hi)) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h..0x%08h", tag, obs, lo, hi);
    end
  endtask

  // ---------------- bus driver ----------------
  task automatic ahb_xfer_wr(input logic [15:0] addr, input logic [2:0] size, input logic [31:0] data,
                             input logic [1:0] trans, input logic sel);
    @(negedge HCLK);
    HSEL = sel; HADDR = addr; HWRITE = 1'b1; HSIZE = size; HTRANS = trans;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
  endtask

  task automatic ahb_write(input logic [15:0] addr, input logic [31:0] data);
    ahb_xfer_wr(addr, 3'd2, data, 2'b10, 1'b1);
  endtask

  task automatic ahb_read(input logic [15:0] addr, output logic [31:0] data);
    @(negedge HCLK);
    HSEL = 1'b1; HADDR = addr; HWRITE = 1'b0; HSIZE = 3'd2; HTRANS = 2'b10;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    data = HRDATA;
  endtask

  // write immediately followed by a pipelined read of the same address
  task automatic ahb_wr_rd(input logic [15:0] addr, input logic [31:0] wdata, output logic [31:0] rdata);
    @(negedge HCLK);
    HSEL = 1'b1; HADDR = addr; HWRITE = 1'b1; HSIZE = 3'd2; HTRANS = 2'b10;
    @(negedge HCLK);
    HWDATA = wdata; HWRITE = 1'b0; HTRANS = 2'b10;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    rdata = HRDATA;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [2:0] size, input logic [1:0] a);
    logic [31:0] res;
    int nb;
    int first;
    res = old_v;
    if (size == 3'd0) begin nb = 1; first = int'(a); end
    else if (size == 3'd1) begin nb = 2; first = a[1] ? 2 : 0; end
    else begin nb = 4; first = 0; end
    for (int b = first; b < first + nb; b++) res[8*b +: 8] = new_v[8*b +: 8];
    return res;
  endfunction

  function automatic logic [31:0] exp_ipend();
    logic [31:0] r;
    r = '0;
    for (int n = 0; n < TIMERS; n++) r[n] = (m_time >= m_cmp[n]);
    return r;
  endfunction

  function automatic logic [31:0] exp_read(input logic [15:0] addr);
    int idx;
    idx = int'(addr[7:2]);
    if (idx == 0) return {31'b0, m_en};
`ifdef AHB3_MTIMER_PRESCALER_EN
    if (idx == 1) return m_presc;
`endif
    if (idx == 2) return exp_ipend();
    if (idx == 3) return m_ien;
    if (idx == 4) return m_time[31:0];
    if (idx == 5) return m_time[63:32];
    if (idx >= 6 && idx < 6 + 2 * TIMERS) begin
      if (((idx - 6) % 2) == 0) return m_cmp[(idx - 6) / 2][31:0];
      else return m_cmp[(idx - 6) / 2][63:32];
    end
    return 32'h0;
  endfunction

  task automatic model_write(input logic [15:0] addr, input logic [2:0] size, input logic [31:0] data);
    int idx;
    int n;
    logic [31:0] v;
    idx = int'(addr[7:2]);
    if (idx == 0) begin v = lanes({31'b0, m_en}, data, size, addr[1:0]); m_en = v[0]; end
    else if (idx == 1) m_presc = lanes(m_presc, data, size, addr[1:0]);
    else if (idx == 3) m_ien = lanes(m_ien, data, size, addr[1:0]) & IEN_MASK;
    else if (idx == 4) m_time[31:0] = lanes(m_time[31:0], data, size, addr[1:0]);
    else if (idx == 5) m_time[63:32] = lanes(m_time[63:32], data, size, addr[1:0]);
    else if (idx >= 6 && idx < 6 + 2 * TIMERS) begin
      n = (idx - 6) / 2;
      if (((idx - 6) % 2) == 0) m_cmp[n][31:0] = lanes(m_cmp[n][31:0], data, size, addr[1:0]);
      else m_cmp[n][63:32] = lanes(m_cmp[n][63:32], data, size, addr[1:0]);
    end
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [2:0] size, input logic [31:0] data);
    ahb_xfer_wr(addr, size, data, 2'b10, 1'b1);
    model_write(addr, size, data);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic [15:0] a;
    logic [2:0]  sz;
    logic [31:0] d;
    int          r;
    int          seen;

    // reset
    HRESETn = 1'b0;
    wait_cycles(3);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_hreadyout", {31'b0, HREADYOUT}, 32'h1);
    check("rst_hresp", {31'b0, HRESP}, 32'h0);
    HRESETn = 1'b1;
    ahb_read(16'h00, rd); check("rst_control", rd, 32'h0);
    ahb_read(16'h10, rd); check("rst_time_lo", rd, 32'h0);
    ahb_read(16'h14, rd); check("rst_time_hi", rd, 32'h0);
    ahb_read(16'h08, rd); check("rst_ipending", rd, 32'h0);
    ahb_read(16'h18, rd); check("rst_timecmp0_lo", rd, 32'hFFFF_FFFF);
    ahb_read(16'h2C, rd); check("rst_timecmp2_hi", rd, 32'hFFFF_FFFF);
    check("rst_tint", {31'b0, tint}, 32'h0);

    // counting rate: 40 cycles of enable
`ifdef AHB3_MTIMER_PRESCALER_EN
    ahb_write(16'h04, 32'd3);
    ahb_write(16'h00, 32'd1);
    wait_cycles(40);
    ahb_read(16'h10, rd); check_range("presc3_time", rd, 32'd9, 32'd11);
`else
    ahb_write(16'h00, 32'd1);
    wait_cycles(40);
    ahb_read(16'h10, rd); check_range("free_time", rd, 32'd40, 32'd42);
`endif
    ahb_write(16'h00, 32'd0);
    ahb_read(16'h10, rd); d = rd;
    wait_cycles(5);
    ahb_read(16'h10, rd); check("hold_when_disabled", rd, d);

    // interrupt on channel 1
    ahb_write(16'h10, 32'h0);
    ahb_write(16'h14, 32'h0);
    ahb_write(16'h04, 32'h0);
    ahb_write(16'h20, 32'h20);
    ahb_write(16'h24, 32'h0);
    ahb_write(16'h0C, 32'b010);
    ahb_write(16'h00, 32'd1);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge HCLK);
      if (tint) begin seen = 1; break; end
    end
    check("tint_rise", seen, 32'd1);
    ahb_read(16'h10, rd); check_range("time_at_irq", rd, 32'h20, 32'h60);
    ahb_read(16'h08, rd); check("ipending_ch1", rd, 32'b010);
    ahb_write(16'h20, 32'hFFFF_FFFF);
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge HCLK);
      if (!tint) begin seen = 1; break; end
    end
    check("tint_fall", seen, 32'd1);

    // pending without enable
    ahb_write(16'h00, 32'd0);
    ahb_write(16'h0C, 32'd0);
    ahb_write(16'h18, 32'h10);
    ahb_write(16'h1C, 32'h0);
    wait_cycles(2);
    ahb_read(16'h08, rd); check("ipending_ch0_masked", rd, 32'b001);
    check("tint_masked", {31'b0, tint}, 32'h0);
    ahb_write(16'h0C, 32'b001);
    wait_cycles(2);
    check("tint_unmasked", {31'b0, tint}, 32'h1);
    ahb_write(16'h08, 32'h0);
    ahb_read(16'h08, rd); check("ipending_ro", rd, 32'b001);
    ahb_write(16'h0C, 32'd0);

    // byte lanes
    ahb_write(16'h04, 32'h0);
    ahb_xfer_wr(16'h05, 3'd0, 32'h0000_AB00, 2'b10, 1'b1);
    ahb_read(16'h04, rd);
`ifdef AHB3_MTIMER_PRESCALER_EN
    check("presc_byte", rd, 32'h0000_AB00);
`else
    check("presc_absent_byte", rd, 32'h0);
`endif
    ahb_xfer_wr(16'h06, 3'd1, 32'h1234_0000, 2'b10, 1'b1);
    ahb_read(16'h04, rd);
`ifdef AHB3_MTIMER_PRESCALER_EN
    check("presc_half", rd, 32'h1234_AB00);
`else
    check("presc_absent_half", rd, 32'h0);
`endif
    ahb_xfer_wr(16'h1A, 3'd0, 32'h00CD_0000, 2'b10, 1'b1);
    ahb_read(16'h18, rd); check("cmp0_byte2", rd, 32'h00CD_0010);
    ahb_wr_rd(16'h0C, 32'h0000_0005, rd); check("wr_then_rd", rd, 32'h5);

    // 32-bit carry into TIME hi
    ahb_write(16'h04, 32'h0);
    ahb_write(16'h00, 32'd0);
    ahb_write(16'h10, 32'hFFFF_FFFE);
    ahb_write(16'h14, 32'h0);
    ahb_write(16'h00, 32'd1);
    ahb_write(16'h00, 32'd0);
    ahb_read(16'h14, rd); check("wrap_time_hi", rd, 32'h1);
    ahb_read(16'h10, rd); check("wrap_time_lo", rd, 32'h0);

    // unmapped and ignored transfers
    ahb_read(16'h7C, rd); check("unmapped_7c", rd, 32'h0);
    ahb_read(16'h30, rd); check("unmapped_30", rd, 32'h0);
    ahb_xfer_wr(16'h0C, 3'd2, 32'h2, 2'b00, 1'b1);
    ahb_read(16'h0C, rd); check("idle_write_ignored", rd, 32'h5);
    ahb_xfer_wr(16'h0C, 3'd2, 32'h2, 2'b01, 1'b1);
    ahb_read(16'h0C, rd); check("busy_write_ignored", rd, 32'h5);
    ahb_xfer_wr(16'h0C, 3'd2, 32'h2, 2'b10, 1'b0);
    ahb_read(16'h0C, rd); check("hsel0_write_ignored", rd, 32'h5);

    // randomized register traffic against the model (counter stopped)
    m_en = 1'b0; m_presc = 32'h0; m_ien = 32'h0; m_time = '0;
    for (int n = 0; n < TIMERS; n++) m_cmp[n] = '0;
    do_write(16'h00, 3'd2, 32'h0);
    do_write(16'h04, 3'd2, 32'h0);
    do_write(16'h0C, 3'd2, $urandom);
    do_write(16'h10, 3'd2, $urandom);
    do_write(16'h14, 3'd2, $urandom_range(0, 3));
    for (int n = 0; n < TIMERS; n++) begin
      do_write(16'(16'h18 + 8 * n), 3'd2, $urandom);
      do_write(16'(16'h1C + 8 * n), 3'd2, $urandom_range(0, 3));
    end
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 4 + 2 * TIMERS);
      sz = 3'($urandom_range(0, 2));
      a = 16'(4 + 4 * r);
      if (sz == 3'd0) a[1:0] = 2'($urandom_range(0, 3));
      else if (sz == 3'd1) a[1:0] = {1'($urandom_range(0, 1)), 1'b0};
      if ((r >= 4) && (r % 2 == 0)) d = $urandom_range(0, 3) * 32'h0101_0101;
      else d = $urandom;
      do_write(a, sz, d);
      ahb_read({a[15:2], 2'b00}, rd); check("rand_readback", rd, exp_read({a[15:2], 2'b00}));
      ahb_read(16'h08, rd); check("rand_ipending", rd, exp_ipend());
      check("rand_tint", {31'b0, tint}, {31'b0, |(exp_ipend() & m_ien)});
    end

    // reset during a write data phase aborts the write
    @(negedge HCLK);
    HSEL = 1'b1; HADDR = 16'h0C; HWRITE = 1'b1; HSIZE = 3'd2; HTRANS = 2'b10;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h7; HRESETn = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    wait_cycles(2);
    ahb_read(16'h0C, rd); check("reset_abort_ienable", rd, 32'h0);
    ahb_read(16'h1C, rd); check("reset_abort_cmp0_hi", rd, 32'hFFFF_FFFF);
    check("reset_abort_tint", {31'b0, tint}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
